// File: rtl/multi_ch_blinker.sv
// multi_ch_blinker: NUM_CH independent programmable square-wave outputs with valid/ready config, per-channel enable, global sync; optional tick outputs under BLINKER_TICK_EN
module multi_ch_blinker #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 24,
  parameter int DEFAULT_HALF = 4194304,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] blink_out
`ifdef BLINKER_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t state_q;
  logic [CH_W-1:0] cap_ch_q;
  logic [CNT_W-1:0] cap_half_q;
  logic [CNT_W-1:0] half_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] out_q, out_d, tgl_d, hit, last;
  logic err_q, ch_ok;
  assign ch_ok = 32'(cap_ch_q) < NUM_CH;
  assign cfg_ready = !rst && state_q == IDLE;
  assign cfg_err = err_q;
  assign blink_out = out_q;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = state_q == APPLY && cap_ch_q == CH_W'(i);
      last[i] = half_q[i] == '0 || cnt_q[i] == half_q[i] - 1'b1;
      cnt_d[i] = (sync || hit[i]) ? '0 : !ch_en[i] ? cnt_q[i] : last[i] ? '0 : cnt_q[i] + 1'b1;
      tgl_d[i] = !sync && !hit[i] && ch_en[i] && last[i];
      out_d[i] = sync ? 1'b0 : out_q[i] ^ tgl_d[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q <= 1'b0;
      out_q <= '0;
      cap_ch_q <= '0;
      cap_half_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        half_q[i] <= CNT_W'(DEFAULT_HALF);
      end
    end else begin
      out_q <= out_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      if (state_q == APPLY) begin
        state_q <= IDLE;
        if (ch_ok) half_q[cap_ch_q] <= cap_half_q;
        else err_q <= 1'b1;
      end else if (cfg_valid) begin
        state_q <= APPLY;
        cap_ch_q <= cfg_ch;
        cap_half_q <= cfg_half;
      end
    end
  end
`ifdef BLINKER_TICK_EN
  logic [NUM_CH-1:0] tick_q;
  assign tick = tick_q;
  always_ff @(posedge clk) tick_q <= rst ? '0 : tgl_d;
`endif
endmodule

// File: tb/tb_multi_ch_blinker.sv
// tb_multi_ch_blinker: directed plus randomized stimulus checked against a countdown-based reference model
module tb_multi_ch_blinker;
  localparam int N = 3;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, cfg_err, sync;
  logic [1:0] cfg_ch;
  logic [W-1:0] cfg_half;
  logic [N-1:0] ch_en, blink_out;
`ifdef BLINKER_TICK_EN
  logic [N-1:0] tick;
`endif
  always #5 clk = ~clk;
  multi_ch_blinker #(.NUM_CH(N), .CNT_W(W), .DEFAULT_HALF(4)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_err(cfg_err),
    .ch_en(ch_en), .sync(sync), .blink_out(blink_out)
`ifdef BLINKER_TICK_EN
    , .tick(tick)
`endif
  );
  int checks = 0;
  int failures = 0;
  int h [N];
  int rem [N];
  logic [N-1:0] m_out, m_tick;
  logic m_busy, m_err;
  int m_ch, m_half;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int eff(int x);
    return x == 0 ? 1 : x;
  endfunction
  task automatic step(logic r, logic v, logic [1:0] c, logic [W-1:0] hf, logic [N-1:0] e, logic s);
    rst = r;
    cfg_valid = v;
    cfg_ch = c;
    cfg_half = hf;
    ch_en = e;
    sync = s;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < N; i++) begin
        h[i] = 4;
        rem[i] = 4;
      end
      m_out = '0;
      m_tick = '0;
      m_busy = 1'b0;
      m_err = 1'b0;
    end else begin
      if (m_busy) begin
        if (m_ch < N) h[m_ch] = m_half;
        else m_err = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        m_tick[i] = 1'b0;
        if (s) begin
          m_out[i] = 1'b0;
          rem[i] = eff(h[i]);
        end else if (m_busy && m_ch == i) begin
          rem[i] = eff(h[i]);
        end else if (e[i]) begin
          rem[i]--;
          if (rem[i] == 0) begin
            m_out[i] = ~m_out[i];
            m_tick[i] = 1'b1;
            rem[i] = eff(h[i]);
          end
        end
      end
      if (m_busy) m_busy = 1'b0;
      else if (v) begin
        m_busy = 1'b1;
        m_ch = int'(c);
        m_half = int'(hf);
      end
    end
    #1;
    check("blink_out", 32'(blink_out), 32'(m_out));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("cfg_ready", 32'(cfg_ready), 32'(!r && !m_busy));
`ifdef BLINKER_TICK_EN
    check("tick", 32'(tick), 32'(m_tick));
`endif
    @(negedge clk);
  endtask
  initial begin
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    repeat (12) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 1, 2, '1, 0);
    repeat (10) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 0, 0, '1, 0);
    repeat (6) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 3, 5, '1, 0);
    repeat (3) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 0, 4, '1, 0);
    step(0, 0, 0, 0, '1, 0);
    step(0, 0, 0, 0, '1, 0);
    repeat (10) step(0, 0, 0, 0, 3'b110, 0);
    repeat (6) step(0, 0, 0, 0, '1, 0);
    step(0, 0, 0, 0, '1, 1);
    repeat (8) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 2, 3, '1, 0);
    step(0, 0, 0, 0, '1, 1);
    repeat (8) step(0, 0, 0, 0, '1, 0);
    step(0, 1, 1, 5, '1, 0);
    step(1, 0, 0, 0, '1, 0);
    repeat (6) step(0, 0, 0, 0, '1, 0);
    repeat (3000) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
           W'($urandom_range(0, 6)), {$urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0},
           $urandom_range(0, 39) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
